sha3_burst_dispatcher: RTL
==========================

SHA3_BURST_DISPATCHER -- requirements
Module: sha3_burst_dispatcher

Interface
REQ-001 Parameter BURST_LEN, default 26: hashes per core burst; SHALL equal the core's burst length (24 + feedback-mux latency + 1).
REQ-002 Parameter NONCE_LANE, default 19: flat lane index (row*5+col) whose low 32 bits carry the nonce.
REQ-003 Parameter RESULT_LANE, default 3: flat output lane compared against target.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  one-cycle request to begin a scan; ignored unless idle.
REQ-007 tmpl  in  25x64  template state, lane order row-major (a0..e4).
REQ-008 nonce_base  in  32  first nonce; burst_count  in  16  number of bursts to issue.
REQ-009 target  in  64  unsigned threshold; hit when result lane <= target.
REQ-010 core_gimme  in  1  core ready for a new burst; core_sample  out  1  burst request to core.
REQ-011 rowa..rowe  out  5x64 each  state to core; core_ogood  in  1; oa..oe  in  5x64 each  core results.
REQ-012 found  out  1  hit pulse; found_nonce  out  32  nonce of hit; busy  out  1; done  out  1  scan-complete pulse.

Function
REQ-013 FSM states IDLE, WAIT_GIMME, BURST, DRAIN; encoding from package.
REQ-014 IDLE: on start, latch tmpl, target, burst_count; load issue_nonce and result_nonce with nonce_base; go WAIT_GIMME, or go DRAIN if burst_count==0.
REQ-015 WAIT_GIMME: core_sample=core_gimme; when core_gimme=1 go BURST with burst counter=1.
REQ-016 BURST: core_sample=1 for exactly BURST_LEN cycles including the entry cycle; core_gimme ignored once burst started.
REQ-017 Rows SHALL always present latched template with lane NONCE_LANE low 32 bits = issue_nonce, high 32 bits from template; valid every cycle (core samples while its gimme is high).
REQ-018 issue_nonce increments by 1 on every cycle core_sample=1 and core_gimme or BURST; wraps modulo 2^32.
REQ-019 End of burst: decrement bursts_left; zero -> DRAIN, else WAIT_GIMME; core_sample=0 the cycle after the last burst cycle.
REQ-020 issued counter (32 bit) increments per issued hash; received counter increments per core_ogood cycle.
REQ-021 Each core_ogood cycle: result_nonce increments (wrap 2^32); registered compare of RESULT_LANE vs target.
REQ-022 found=1 exactly one cycle after a qualifying core_ogood cycle, found_nonce = nonce of that result; back-to-back hits give back-to-back pulses.
REQ-023 DRAIN: when received==issued and no compare pending, done=1 for one cycle, go IDLE.
REQ-024 busy=1 in every state except IDLE.
REQ-025 core_ogood while IDLE SHALL be ignored (no found, counters unchanged).
REQ-026 start asserted while busy SHALL have no effect.

Reset
REQ-027 rst_n=0 at a clock edge: state IDLE; core_sample, found, done, busy=0; found_nonce=0; all counters 0; rows drive 0.
REQ-028 Reset mid-burst SHALL abort immediately; no found/done after release until a new start.

Structure
REQ-029 Package sha3_scan_pkg SHALL hold the FSM state enum, default BURST_LEN, lane-index constants and lane-array typedef.
REQ-030 One sub-module sha3_result_compare (registered lane select + <= compare + nonce tag); the rest is flat.

Verification
REQ-031 burst_count=1, nonce_base=0x10, core model: core_sample high 26 cycles, nonce lane 0x10..0x29, done after 26th ogood.
REQ-032 target=all-ones, burst_count=2: 52 found pulses, found_nonce sequential from nonce_base, one done.
REQ-033 nonce_base=0xFFFFFFF0, burst_count=1: issued nonces wrap through 0x0 to 0x9; hit forced on result 20 gives found_nonce=0x4.
REQ-034 burst_count=0: done one cycle after start, core_sample never asserted.
REQ-035 rst_n low during cycle 10 of a burst: core_sample low next cycle, busy=0, no found/done on subsequent stray ogood.
REQ-036 start pulsed during DRAIN: ignored; latched target/template unchanged, single done.

Source files
------------

// File: rtl/sha3_scan_pkg.sv
// Shared types and constants for the SHA-3 nonce-scan dispatcher and its result comparator.
package sha3_scan_pkg;
  localparam int LANES           = 25;
  localparam int ROW_LANES       = 5;
  localparam int LANE_W          = 64;
  localparam int DEF_BURST_LEN   = 26;
  localparam int DEF_NONCE_LANE  = 19;
  localparam int DEF_RESULT_LANE = 3;

  typedef logic [LANE_W-1:0]                lane_t;
  typedef logic [LANES-1:0][LANE_W-1:0]     lanes_t;
  typedef logic [ROW_LANES-1:0][LANE_W-1:0] row_t;

  typedef enum logic [1:0] {IDLE, WAIT_GIMME, BURST, DRAIN} state_t;
endpackage

// File: rtl/sha3_burst_dispatcher_if.sv
// Handshake and row/result buses between the dispatcher (master) and the Keccak core (slave).
interface sha3_burst_dispatcher_if import sha3_scan_pkg::*; ;
  logic core_gimme;
  logic core_sample;
  logic core_ogood;
  row_t rowa, rowb, rowc, rowd, rowe;
  row_t oa, ob, oc, od, oe;

  modport master (
    input  core_gimme, core_ogood, oa, ob, oc, od, oe,
    output core_sample, rowa, rowb, rowc, rowd, rowe
  );

  modport slave (
    output core_gimme, core_ogood, oa, ob, oc, od, oe,
    input  core_sample, rowa, rowb, rowc, rowd, rowe
  );
endinterface

// File: rtl/sha3_result_compare.sv
// Registered selection of one result lane, unsigned <= compare against target, tagged with its nonce.
module sha3_result_compare import sha3_scan_pkg::*; #(
  parameter int RESULT_LANE = DEF_RESULT_LANE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld_p0,
  input  row_t        oa,
  input  row_t        ob,
  input  row_t        oc,
  input  row_t        od,
  input  row_t        oe,
  input  lane_t       target,
  input  logic [31:0] tag_p0,
  output logic        found,
  output logic [31:0] found_nonce
);
  lanes_t res_p0;
  lane_t  sel_p0;
  logic   hit_p0;

  assign res_p0 = {oe, od, oc, ob, oa};
  assign sel_p0 = res_p0[RESULT_LANE];
  assign hit_p0 = vld_p0 && (sel_p0 <= target);

  // p0 -> p1: hit flag and its nonce
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      found       <= 1'b0;
      found_nonce <= '0;
    end else begin
      found <= hit_p0;
      if (hit_p0) found_nonce <= tag_p0;
    end
  end
endmodule

// File: rtl/sha3_burst_dispatcher.sv
// Feeds template+nonce states to a Keccak core in fixed bursts and reports nonces whose result lane meets target.
module sha3_burst_dispatcher import sha3_scan_pkg::*; #(
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int NONCE_LANE  = DEF_NONCE_LANE,
  parameter int RESULT_LANE = DEF_RESULT_LANE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  lanes_t                    tmpl,
  input  logic [31:0]               nonce_base,
  input  logic [15:0]               burst_count,
  input  lane_t                     target,
  sha3_burst_dispatcher_if.master   core,
  output logic                      found,
  output logic [31:0]               found_nonce,
  output logic                      busy,
  output logic                      done
);
  state_t      state;
  lanes_t      tmpl_q;
  lane_t       target_q;
  lanes_t      lanes;
  logic [15:0] bursts_left;
  logic [15:0] burst_cnt;
  logic [31:0] issue_nonce;
  logic [31:0] result_nonce;
  logic [31:0] issued;
  logic [31:0] received;
  logic        ogood_act;

  // The core only samples while requested, so rows can stay valid every cycle.
  always_comb begin
    lanes = tmpl_q;
    lanes[NONCE_LANE][31:0] = issue_nonce;
  end

  assign core.rowa = lanes[4:0];
  assign core.rowb = lanes[9:5];
  assign core.rowc = lanes[14:10];
  assign core.rowd = lanes[19:15];
  assign core.rowe = lanes[24:20];

  assign core.core_sample = (state == BURST) || ((state == WAIT_GIMME) && core.core_gimme);
  assign ogood_act        = core.core_ogood && (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      tmpl_q       <= '0;
      target_q     <= '0;
      bursts_left  <= '0;
      burst_cnt    <= '0;
      issue_nonce  <= '0;
      result_nonce <= '0;
      issued       <= '0;
      received     <= '0;
    end else begin
      done <= 1'b0;
      if (core.core_sample) begin
        issue_nonce <= issue_nonce + 32'd1;
        issued      <= issued + 32'd1;
      end
      if (ogood_act) begin
        result_nonce <= result_nonce + 32'd1;
        received     <= received + 32'd1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            tmpl_q       <= tmpl;
            target_q     <= target;
            bursts_left  <= burst_count;
            issue_nonce  <= nonce_base;
            result_nonce <= nonce_base;
            issued       <= '0;
            received     <= '0;
            busy         <= 1'b1;
            state        <= (burst_count == 16'd0) ? DRAIN : WAIT_GIMME;
          end
        end
        WAIT_GIMME: begin
          // The gimme cycle itself is the first sampled hash of the burst.
          if (core.core_gimme) begin
            burst_cnt <= 16'd1;
            state     <= BURST;
          end
        end
        BURST: begin
          if (burst_cnt == 16'(BURST_LEN - 1)) begin
            bursts_left <= bursts_left - 16'd1;
            state       <= (bursts_left == 16'd1) ? DRAIN : WAIT_GIMME;
          end else begin
            burst_cnt <= burst_cnt + 16'd1;
          end
        end
        DRAIN: begin
          if ((received == issued) && !ogood_act) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sha3_result_compare #(
    .RESULT_LANE (RESULT_LANE)
  ) u_cmp (
    .clk         (clk),
    .rst_n       (rst_n),
    .vld_p0      (ogood_act),
    .oa          (core.oa),
    .ob          (core.ob),
    .oc          (core.oc),
    .od          (core.od),
    .oe          (core.oe),
    .target      (target_q),
    .tag_p0      (result_nonce),
    .found       (found),
    .found_nonce (found_nonce)
  );
endmodule
